// File: rtl/chacha_pkg.sv
// Shared constants for the ChaCha round engine: word geometry, rotation
// amounts, quarterround index tables and FSM state encoding.
package chacha_pkg;

  localparam int WORD_W      = 32;
  localparam int STATE_WORDS = 16;

  localparam int ROT_0 = 16;
  localparam int ROT_1 = 12;
  localparam int ROT_2 = 8;
  localparam int ROT_3 = 7;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ROUND = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef logic [WORD_W-1:0] word_t;

  // Rows 0-3: column round tuples, rows 4-7: diagonal round tuples.
  localparam logic [3:0] QR_IDX [8][4] = '{
    '{4'd0, 4'd4, 4'd8,  4'd12},
    '{4'd1, 4'd5, 4'd9,  4'd13},
    '{4'd2, 4'd6, 4'd10, 4'd14},
    '{4'd3, 4'd7, 4'd11, 4'd15},
    '{4'd0, 4'd5, 4'd10, 4'd15},
    '{4'd1, 4'd6, 4'd11, 4'd12},
    '{4'd2, 4'd7, 4'd8,  4'd13},
    '{4'd3, 4'd4, 4'd9,  4'd14}
  };

  function automatic word_t rotl(input word_t x, input int n);
    return (x << n) | (x >> (WORD_W - n));
  endfunction

  function automatic logic [3:0] qr_word(input logic diag, input logic [1:0] tuple,
                                         input logic [1:0] pos);
    return QR_IDX[{diag, tuple}][pos];
  endfunction

endpackage

// File: rtl/chacha_qr_comb.sv
// Single ChaCha quarterround (RFC 8439), purely combinational.
module chacha_qr_comb
  import chacha_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic [WORD_W-1:0] c,
  input  logic [WORD_W-1:0] d,
  output logic [WORD_W-1:0] a_prim,
  output logic [WORD_W-1:0] b_prim,
  output logic [WORD_W-1:0] c_prim,
  output logic [WORD_W-1:0] d_prim
);

  word_t a1, b1, c1, d1;
  word_t a2, b2, c2, d2;

  always_comb begin
    a1 = a + b;
    d1 = rotl(d ^ a1, ROT_0);
    c1 = c + d1;
    b1 = rotl(b ^ c1, ROT_1);
    a2 = a1 + b1;
    d2 = rotl(d1 ^ a2, ROT_2);
    c2 = c1 + d2;
    b2 = rotl(b1 ^ c2, ROT_3);
    a_prim = a2;
    b_prim = b2;
    c_prim = c2;
    d_prim = d2;
  end

endmodule

// File: rtl/chacha_round_engine.sv
// Iterative ChaCha permutation with NUM_QR quarterround units per cycle.
// Define CHACHA_FEEDFWD_EN to add the input state back into the result.
//
// Handshake: start is sampled only while ready=1 (IDLE or DONE); the accepting
// edge loads state_in and valid stays 0 until the result is complete, after
// which state_out and valid=1 hold until the next accepted start.
module chacha_round_engine
  import chacha_pkg::*;
#(
  parameter int NUM_QR = 4,
  parameter int ROUNDS = 20
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [511:0] state_in,
  output logic         ready,
  output logic [511:0] state_out,
  output logic         valid
);

  localparam int         STEPS     = 4 / NUM_QR;
  localparam int         RW        = $clog2(ROUNDS);
  localparam logic [1:0] STEP_LAST = 2'(STEPS - 1);

  generate
    if (!(NUM_QR == 1 || NUM_QR == 2 || NUM_QR == 4)) begin : g_bad_num_qr
      $error("chacha_round_engine: NUM_QR must be 1, 2 or 4");
    end
    if ((ROUNDS < 2) || ((ROUNDS % 2) != 0)) begin : g_bad_rounds
      $error("chacha_round_engine: ROUNDS must be even and at least 2");
    end
  endgenerate

  logic [1:0]    fsm_q;
  logic [1:0]    step_ctr;
  logic [RW-1:0] round_ctr;
  word_t         work_q   [STATE_WORDS];
  word_t         work_d   [STATE_WORDS];
  word_t         in_words [STATE_WORDS];
  logic [511:0]  res_flat;
  logic [511:0]  out_q;
  logic          last_step;

  logic [3:0] sel   [NUM_QR][4];
  word_t      qa_n  [NUM_QR];
  word_t      qb_n  [NUM_QR];
  word_t      qc_n  [NUM_QR];
  word_t      qd_n  [NUM_QR];

`ifdef CHACHA_FEEDFWD_EN
  word_t copy_q [STATE_WORDS];
`endif

  always_comb begin
    for (int i = 0; i < STATE_WORDS; i++) begin
      in_words[i] = state_in[511-32*i -: 32];
    end
  end

  // Unit k works on tuple step*NUM_QR+k; round parity picks column or diagonal.
  always_comb begin
    for (int k = 0; k < NUM_QR; k++) begin
      for (int p = 0; p < 4; p++) begin
        sel[k][p] = qr_word(round_ctr[0], 2'(int'(step_ctr) * NUM_QR + k), 2'(p));
      end
    end
  end

  generate
    for (genvar k = 0; k < NUM_QR; k++) begin : g_qr
      chacha_qr_comb u_qr (
        .a      (work_q[sel[k][0]]),
        .b      (work_q[sel[k][1]]),
        .c      (work_q[sel[k][2]]),
        .d      (work_q[sel[k][3]]),
        .a_prim (qa_n[k]),
        .b_prim (qb_n[k]),
        .c_prim (qc_n[k]),
        .d_prim (qd_n[k])
      );
    end
  endgenerate

  // Tuples within one step never share a word, so write-back order is irrelevant.
  always_comb begin
    work_d = work_q;
    for (int k = 0; k < NUM_QR; k++) begin
      work_d[sel[k][0]] = qa_n[k];
      work_d[sel[k][1]] = qb_n[k];
      work_d[sel[k][2]] = qc_n[k];
      work_d[sel[k][3]] = qd_n[k];
    end
  end

  always_comb begin
    res_flat = '0;
    for (int i = 0; i < STATE_WORDS; i++) begin
`ifdef CHACHA_FEEDFWD_EN
      res_flat[511-32*i -: 32] = work_d[i] + copy_q[i];
`else
      res_flat[511-32*i -: 32] = work_d[i];
`endif
    end
  end

  assign last_step = (round_ctr == RW'(ROUNDS - 1)) && (step_ctr == STEP_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q     <= ST_IDLE;
      step_ctr  <= '0;
      round_ctr <= '0;
      out_q     <= '0;
      for (int i = 0; i < STATE_WORDS; i++) begin
        work_q[i] <= '0;
`ifdef CHACHA_FEEDFWD_EN
        copy_q[i] <= '0;
`endif
      end
    end else begin
      case (fsm_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            fsm_q     <= ST_ROUND;
            step_ctr  <= '0;
            round_ctr <= '0;
            work_q    <= in_words;
`ifdef CHACHA_FEEDFWD_EN
            copy_q    <= in_words;
`endif
          end
        end
        ST_ROUND: begin
          work_q <= work_d;
          if (last_step) begin
            fsm_q     <= ST_DONE;
            step_ctr  <= '0;
            round_ctr <= '0;
            out_q     <= res_flat;
          end else if (step_ctr == STEP_LAST) begin
            step_ctr  <= '0;
            round_ctr <= round_ctr + 1'b1;
          end else begin
            step_ctr  <= step_ctr + 1'b1;
          end
        end
        default: fsm_q <= ST_IDLE;
      endcase
    end
  end

  assign ready     = (fsm_q != ST_ROUND);
  assign valid     = (fsm_q == ST_DONE);
  assign state_out = out_q;

endmodule
